ctrl_seq_hs: RTL and testbench

- Parametrised multi-cycle control unit for the ezRISC datapath; successor to the fixed-timing FSM.
- Adds three things the fixed-timing FSM lacks: variable-latency memory handshake, multi-cycle ALU start/done handshake, and a wait timeout to a FAULT state.
- Also adds stop/resume at instruction boundaries and a retired-instruction counter.
- Drives the datapath through a packed control word; decodes the opcode from the IR into instruction classes.

---
 rtl/ctrl_pkg.sv | 130 +++++++++++++
 rtl/ctrl_decode.sv | 54 +++++
 rtl/ctrl_seq_hs.sv | 254 +++++++++++++++++++++++++
 tb/tb_ctrl_seq_hs.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the ezRISC multi-cycle control unit.
// Holds the opcode map, ALU operation codes, datapath control-word bit
// indices, FSM state encodings and instruction-class enumeration.
package ctrl_pkg;

    // Legacy opcode encoding (27..31 are illegal).
    localparam int OP_LD   = 0;
    localparam int OP_LDI  = 1;
    localparam int OP_ST   = 2;
    localparam int OP_ADD  = 3;
    localparam int OP_SUB  = 4;
    localparam int OP_SHR  = 5;
    localparam int OP_SHL  = 6;
    localparam int OP_ROR  = 7;
    localparam int OP_ROL  = 8;
    localparam int OP_AND  = 9;
    localparam int OP_OR   = 10;
    localparam int OP_ADDI = 11;
    localparam int OP_ANDI = 12;
    localparam int OP_ORI  = 13;
    localparam int OP_MUL  = 14;
    localparam int OP_DIV  = 15;
    localparam int OP_NEG  = 16;
    localparam int OP_NOT  = 17;
    localparam int OP_BR   = 18;
    localparam int OP_JR   = 19;
    localparam int OP_JAL  = 20;
    localparam int OP_IN   = 21;
    localparam int OP_OUT  = 22;
    localparam int OP_MFHI = 23;
    localparam int OP_MFLO = 24;
    localparam int OP_NOP  = 25;
    localparam int OP_HALT = 26;

    // ALU operation select codes.
    localparam int ALU_AND = 0;
    localparam int ALU_OR  = 1;
    localparam int ALU_ADD = 2;
    localparam int ALU_SUB = 3;
    localparam int ALU_MUL = 4;
    localparam int ALU_DIV = 5;
    localparam int ALU_SHR = 6;
    localparam int ALU_SHL = 7;
    localparam int ALU_ROR = 8;
    localparam int ALU_ROL = 9;
    localparam int ALU_NEG = 10;
    localparam int ALU_NOT = 11;

    // Packed datapath control word.
    localparam int CTLW           = 26;
    localparam int CTL_GRA        = 0;
    localparam int CTL_GRB        = 1;
    localparam int CTL_GRC        = 2;
    localparam int CTL_R_IN       = 3;
    localparam int CTL_R_OUT      = 4;
    localparam int CTL_BA_OUT     = 5;
    localparam int CTL_HI_IN      = 6;
    localparam int CTL_HI_OUT     = 7;
    localparam int CTL_LO_IN      = 8;
    localparam int CTL_LO_OUT     = 9;
    localparam int CTL_PC_IN      = 10;
    localparam int CTL_PC_OUT     = 11;
    localparam int CTL_IR_IN      = 12;
    localparam int CTL_Z_IN       = 13;
    localparam int CTL_Z_HIGH_OUT = 14;
    localparam int CTL_Z_LOW_OUT  = 15;
    localparam int CTL_INPORT_OUT = 16;
    localparam int CTL_C_OUT      = 17;
    localparam int CTL_Y_IN       = 18;
    localparam int CTL_MAR_IN     = 19;
    localparam int CTL_OUTPORT_IN = 20;
    localparam int CTL_MDR_IN     = 21;
    localparam int CTL_MDR_OUT    = 22;
    localparam int CTL_INC_PC     = 23;
    localparam int CTL_CON_IN     = 24;
    localparam int CTL_LINK_SEL   = 25;

    typedef enum logic [5:0] {
        S_RST   = 6'd0,
        S_F0    = 6'd1,
        S_F1    = 6'd2,
        S_FM    = 6'd3,
        S_F2    = 6'd4,
        S_DEC   = 6'd5,
        S_E1    = 6'd6,
        S_EA    = 6'd7,
        S_E3    = 6'd8,
        S_EM    = 6'd9,
        S_MR    = 6'd10,
        S_WB    = 6'd11,
        S_SD    = 6'd12,
        S_MW    = 6'd13,
        S_LO    = 6'd14,
        S_HI    = 6'd15,
        S_B1    = 6'd16,
        S_B2    = 6'd17,
        S_B3    = 6'd18,
        S_B4    = 6'd19,
        S_JR    = 6'd20,
        S_J1    = 6'd21,
        S_J2    = 6'd22,
        S_IN    = 6'd23,
        S_OUT   = 6'd24,
        S_MFHI  = 6'd25,
        S_MFLO  = 6'd26,
        S_HALT  = 6'd27,
        S_FAULT = 6'd28
    } state_t;

    typedef enum logic [4:0] {
        CLS_ALU3   = 5'd0,
        CLS_ALUI   = 5'd1,
        CLS_UNARY  = 5'd2,
        CLS_LD     = 5'd3,
        CLS_LDI    = 5'd4,
        CLS_ST     = 5'd5,
        CLS_MULDIV = 5'd6,
        CLS_BR     = 5'd7,
        CLS_JR     = 5'd8,
        CLS_JAL    = 5'd9,
        CLS_IN     = 5'd10,
        CLS_OUT    = 5'd11,
        CLS_MFHI   = 5'd12,
        CLS_MFLO   = 5'd13,
        CLS_NOP    = 5'd14,
        CLS_HALT   = 5'd15,
        CLS_ILL    = 5'd16
    } cls_t;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode classifier.
//   opcode  in   OPW     opcode field from the IR
//   cls     out  cls_t   instruction class
//   alu_op  out  ALUOPW  ALU operation used in the EA state
//   illegal out  1       opcode outside the legal map
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OPW    = 5,
    parameter int ALUOPW = 4
) (
    input  logic [OPW-1:0]    opcode,
    output cls_t              cls,
    output logic [ALUOPW-1:0] alu_op,
    output logic              illegal
);

    always_comb begin
        cls    = CLS_ILL;
        alu_op = '0;
        case (int'(opcode))
            OP_LD:   begin cls = CLS_LD;     alu_op = ALUOPW'(ALU_ADD); end
            OP_LDI:  begin cls = CLS_LDI;    alu_op = ALUOPW'(ALU_ADD); end
            OP_ST:   begin cls = CLS_ST;     alu_op = ALUOPW'(ALU_ADD); end
            OP_ADD:  begin cls = CLS_ALU3;   alu_op = ALUOPW'(ALU_ADD); end
            OP_SUB:  begin cls = CLS_ALU3;   alu_op = ALUOPW'(ALU_SUB); end
            OP_SHR:  begin cls = CLS_ALU3;   alu_op = ALUOPW'(ALU_SHR); end
            OP_SHL:  begin cls = CLS_ALU3;   alu_op = ALUOPW'(ALU_SHL); end
            OP_ROR:  begin cls = CLS_ALU3;   alu_op = ALUOPW'(ALU_ROR); end
            OP_ROL:  begin cls = CLS_ALU3;   alu_op = ALUOPW'(ALU_ROL); end
            OP_AND:  begin cls = CLS_ALU3;   alu_op = ALUOPW'(ALU_AND); end
            OP_OR:   begin cls = CLS_ALU3;   alu_op = ALUOPW'(ALU_OR);  end
            OP_ADDI: begin cls = CLS_ALUI;   alu_op = ALUOPW'(ALU_ADD); end
            OP_ANDI: begin cls = CLS_ALUI;   alu_op = ALUOPW'(ALU_AND); end
            OP_ORI:  begin cls = CLS_ALUI;   alu_op = ALUOPW'(ALU_OR);  end
            OP_MUL:  begin cls = CLS_MULDIV; alu_op = ALUOPW'(ALU_MUL); end
            OP_DIV:  begin cls = CLS_MULDIV; alu_op = ALUOPW'(ALU_DIV); end
            OP_NEG:  begin cls = CLS_UNARY;  alu_op = ALUOPW'(ALU_NEG); end
            OP_NOT:  begin cls = CLS_UNARY;  alu_op = ALUOPW'(ALU_NOT); end
            OP_BR:   begin cls = CLS_BR;     alu_op = ALUOPW'(ALU_ADD); end
            OP_JR:   cls = CLS_JR;
            OP_JAL:  cls = CLS_JAL;
            OP_IN:   cls = CLS_IN;
            OP_OUT:  cls = CLS_OUT;
            OP_MFHI: cls = CLS_MFHI;
            OP_MFLO: cls = CLS_MFLO;
            OP_NOP:  cls = CLS_NOP;
            OP_HALT: cls = CLS_HALT;
            default: cls = CLS_ILL;
        endcase
        illegal = (cls == CLS_ILL);
    end

endmodule

// File: rtl/ctrl_seq_hs.sv
// ctrl_seq_hs: multi-cycle control unit for the ezRISC datapath with
// memory/ALU handshakes, wait timeout, stop/resume and retire counter.
//   clk, reset_n  clock, synchronous active-low reset
//   ir_data       IR contents (opcode in [OP_LSB+OPW-1:OP_LSB])
//   con_out       branch condition flag
//   mem_ack       memory transfer complete
//   alu_done      ALU result valid
//   stop/resume   halt at next instruction boundary / leave HALT
//   ctl, alu_op   datapath strobes and ALU op select
//   alu_start     one-cycle pulse on entry to EA
//   mem_req/we    memory request and write qualifier
//   run, fault    running / sticky fault status
//   retired       completed-instruction count
//   state_dbg     present state encoding
//
// Handshakes: mem_req is the valid and stays high, with a stable mem_we,
// until a cycle in which mem_ack=1; that cycle completes the transfer and
// the FSM leaves the wait state on the same edge. For the ALU, alu_start
// marks the request and z_in stays high until a cycle with alu_done=1.
module ctrl_seq_hs
    import ctrl_pkg::*;
#(
    parameter int IW           = 32,
    parameter int OPW          = 5,
    parameter int OP_LSB       = 27,
    parameter int ALUOPW       = 4,
    parameter int TMO_W        = 8,
    parameter int WAIT_TIMEOUT = 255,
    parameter int CNTW         = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [IW-1:0]     ir_data,
    input  logic              con_out,
    input  logic              mem_ack,
    input  logic              alu_done,
    input  logic              stop,
    input  logic              resume,
    output logic [CTLW-1:0]   ctl,
    output logic [ALUOPW-1:0] alu_op,
    output logic              alu_start,
    output logic              mem_req,
    output logic              mem_we,
    output logic              run,
    output logic              fault,
    output logic [CNTW-1:0]   retired,
    output logic [5:0]        state_dbg
);

    state_t              state, state_nxt;
    cls_t                cls_q, dec_cls;
    logic [ALUOPW-1:0]   aop_q, dec_aop;
    logic                dec_illegal;
    logic [TMO_W-1:0]    tmo_cnt;
    logic                boundary;
    logic                is_wait, hs_ok, tmo_hit;
    logic                unused_ir;

    ctrl_decode #(.OPW(OPW), .ALUOPW(ALUOPW)) u_decode (
        .opcode  (ir_data[OP_LSB +: OPW]),
        .cls     (dec_cls),
        .alu_op  (dec_aop),
        .illegal (dec_illegal)
    );

    assign unused_ir = ^ir_data;

    assign is_wait = (state == S_FM) || (state == S_MR) ||
                     (state == S_MW) || (state == S_EA);
    assign hs_ok   = (state == S_EA) ? alu_done : mem_ack;
    // The cycle that would make the count reach WAIT_TIMEOUT goes to FAULT.
    assign tmo_hit = (WAIT_TIMEOUT != 0) && is_wait && !hs_ok &&
                     ((int'(tmo_cnt) + 1) == WAIT_TIMEOUT);

    // Next state
    always_comb begin
        state_nxt = state;
        boundary  = 1'b0;
        case (state)
            S_RST: state_nxt = S_F0;
            S_F0:  state_nxt = S_F1;
            S_F1:  state_nxt = S_FM;
            S_FM:  if (mem_ack) state_nxt = S_F2;
            S_F2:  state_nxt = S_DEC;
            S_DEC: begin
                if (dec_illegal) begin
                    state_nxt = S_FAULT;
                end else begin
                    case (dec_cls)
                        CLS_ALU3, CLS_ALUI, CLS_LD, CLS_LDI, CLS_ST,
                        CLS_MULDIV: state_nxt = S_E1;
                        CLS_UNARY:  state_nxt = S_EA;
                        CLS_BR:     state_nxt = S_B1;
                        CLS_JR:     state_nxt = S_JR;
                        CLS_JAL:    state_nxt = S_J1;
                        CLS_IN:     state_nxt = S_IN;
                        CLS_OUT:    state_nxt = S_OUT;
                        CLS_MFHI:   state_nxt = S_MFHI;
                        CLS_MFLO:   state_nxt = S_MFLO;
                        CLS_NOP:    boundary  = 1'b1;
                        CLS_HALT:   state_nxt = S_HALT;
                        default:    state_nxt = S_FAULT;
                    endcase
                end
            end
            S_E1: state_nxt = S_EA;
            S_EA: begin
                if (alu_done) begin
                    case (cls_q)
                        CLS_LD, CLS_ST: state_nxt = S_EM;
                        CLS_MULDIV:     state_nxt = S_LO;
                        default:        state_nxt = S_E3;
                    endcase
                end
            end
            S_EM:  state_nxt = (cls_q == CLS_ST) ? S_SD : S_MR;
            S_MR:  if (mem_ack) state_nxt = S_WB;
            S_SD:  state_nxt = S_MW;
            S_MW:  if (mem_ack) boundary = 1'b1;
            S_LO:  state_nxt = S_HI;
            S_B1:  state_nxt = S_B2;
            S_B2:  state_nxt = S_B3;
            S_B3:  state_nxt = S_B4;
            S_J1:  state_nxt = S_J2;
            S_E3, S_WB, S_HI, S_B4, S_JR, S_J2, S_IN, S_OUT, S_MFHI,
            S_MFLO: boundary = 1'b1;
            S_HALT:  if (resume) state_nxt = S_F0;
            S_FAULT: state_nxt = S_FAULT;
            default: state_nxt = S_FAULT;
        endcase
        if (boundary) state_nxt = stop ? S_HALT : S_F0;
        if (tmo_hit)  state_nxt = S_FAULT;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_RST;
            cls_q     <= CLS_NOP;
            aop_q     <= '0;
            tmo_cnt   <= '0;
            alu_start <= 1'b0;
            retired   <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_DEC) begin
                cls_q <= dec_cls;
                aop_q <= dec_aop;
            end
            if (state_nxt != state)
                tmo_cnt <= '0;
            else if (is_wait)
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            alu_start <= (state_nxt == S_EA) && (state != S_EA);
            if (boundary)
                retired <= retired + CNTW'(1);
        end
    end

    // Moore output decode (B4's pc_in is qualified by con_out).
    always_comb begin
        ctl     = '0;
        alu_op  = '0;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        run     = 1'b1;
        case (state)
            S_F0: begin
                ctl[CTL_PC_OUT] = 1'b1; ctl[CTL_MAR_IN] = 1'b1;
                ctl[CTL_INC_PC] = 1'b1; ctl[CTL_Z_IN]   = 1'b1;
                alu_op = ALUOPW'(ALU_ADD);
            end
            S_F1: begin ctl[CTL_Z_LOW_OUT] = 1'b1; ctl[CTL_PC_IN] = 1'b1; end
            S_FM: begin mem_req = 1'b1; ctl[CTL_MDR_IN] = 1'b1; end
            S_F2: begin ctl[CTL_MDR_OUT] = 1'b1; ctl[CTL_IR_IN] = 1'b1; end
            S_DEC: ;
            S_E1: begin
                ctl[CTL_Y_IN] = 1'b1;
                case (cls_q)
                    CLS_LD, CLS_LDI, CLS_ST: begin
                        ctl[CTL_GRB] = 1'b1; ctl[CTL_BA_OUT] = 1'b1;
                    end
                    CLS_MULDIV: begin
                        ctl[CTL_GRA] = 1'b1; ctl[CTL_R_OUT] = 1'b1;
                    end
                    default: begin
                        ctl[CTL_GRB] = 1'b1; ctl[CTL_R_OUT] = 1'b1;
                    end
                endcase
            end
            S_EA: begin
                ctl[CTL_Z_IN] = 1'b1;
                alu_op = aop_q;
                case (cls_q)
                    CLS_ALU3: begin
                        ctl[CTL_GRC] = 1'b1; ctl[CTL_R_OUT] = 1'b1;
                    end
                    CLS_UNARY, CLS_MULDIV: begin
                        ctl[CTL_GRB] = 1'b1; ctl[CTL_R_OUT] = 1'b1;
                    end
                    default: ctl[CTL_C_OUT] = 1'b1;
                endcase
            end
            S_E3: begin
                ctl[CTL_Z_LOW_OUT] = 1'b1; ctl[CTL_GRA] = 1'b1; ctl[CTL_R_IN] = 1'b1;
            end
            S_EM: begin ctl[CTL_Z_LOW_OUT] = 1'b1; ctl[CTL_MAR_IN] = 1'b1; end
            S_MR: begin mem_req = 1'b1; ctl[CTL_MDR_IN] = 1'b1; end
            S_WB: begin
                ctl[CTL_MDR_OUT] = 1'b1; ctl[CTL_GRA] = 1'b1; ctl[CTL_R_IN] = 1'b1;
            end
            S_SD: begin
                ctl[CTL_GRA] = 1'b1; ctl[CTL_R_OUT] = 1'b1; ctl[CTL_MDR_IN] = 1'b1;
            end
            S_MW: begin mem_req = 1'b1; mem_we = 1'b1; end
            S_LO: begin ctl[CTL_Z_LOW_OUT] = 1'b1; ctl[CTL_LO_IN] = 1'b1; end
            S_HI: begin ctl[CTL_Z_HIGH_OUT] = 1'b1; ctl[CTL_HI_IN] = 1'b1; end
            S_B1: begin
                ctl[CTL_GRA] = 1'b1; ctl[CTL_R_OUT] = 1'b1; ctl[CTL_CON_IN] = 1'b1;
            end
            S_B2: begin ctl[CTL_PC_OUT] = 1'b1; ctl[CTL_Y_IN] = 1'b1; end
            S_B3: begin
                ctl[CTL_C_OUT] = 1'b1; ctl[CTL_Z_IN] = 1'b1;
                alu_op = ALUOPW'(ALU_ADD);
            end
            S_B4: begin ctl[CTL_Z_LOW_OUT] = 1'b1; ctl[CTL_PC_IN] = con_out; end
            S_JR: begin
                ctl[CTL_GRA] = 1'b1; ctl[CTL_R_OUT] = 1'b1; ctl[CTL_PC_IN] = 1'b1;
            end
            S_J1: begin
                ctl[CTL_PC_OUT] = 1'b1; ctl[CTL_R_IN] = 1'b1; ctl[CTL_LINK_SEL] = 1'b1;
            end
            S_J2: begin
                ctl[CTL_GRA] = 1'b1; ctl[CTL_R_OUT] = 1'b1; ctl[CTL_PC_IN] = 1'b1;
            end
            S_IN: begin
                ctl[CTL_GRA] = 1'b1; ctl[CTL_R_IN] = 1'b1; ctl[CTL_INPORT_OUT] = 1'b1;
            end
            S_OUT: begin
                ctl[CTL_GRA] = 1'b1; ctl[CTL_R_OUT] = 1'b1; ctl[CTL_OUTPORT_IN] = 1'b1;
            end
            S_MFHI: begin
                ctl[CTL_HI_OUT] = 1'b1; ctl[CTL_GRA] = 1'b1; ctl[CTL_R_IN] = 1'b1;
            end
            S_MFLO: begin
                ctl[CTL_LO_OUT] = 1'b1; ctl[CTL_GRA] = 1'b1; ctl[CTL_R_IN] = 1'b1;
            end
            default: run = 1'b0;   // RST, HALT, FAULT
        endcase
    end

    assign fault     = (state == S_FAULT);
    assign state_dbg = state;

endmodule

// File: tb/tb_ctrl_seq_hs.sv
// tb_ctrl_seq_hs: cycle-level bench for ctrl_seq_hs. Expected output words
// are queued as each cycle's stimulus is applied and compared at negedge.
module tb_ctrl_seq_hs;
    import ctrl_pkg::*;

    localparam int W = 73;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] ir_data = '0;
    logic        con_out = 1'b0;
    logic        mem_ack = 1'b1;
    logic        alu_done = 1'b1;
    logic        stop = 1'b0;
    logic        resume = 1'b0;
    logic [25:0] ctl;
    logic [3:0]  alu_op;
    logic        alu_start, mem_req, mem_we, run, fault;
    logic [31:0] retired;
    logic [5:0]  state_dbg;

    logic        reset_n_b = 1'b0;
    logic [25:0] b_ctl;
    logic [3:0]  b_alu_op;
    logic        b_alu_start, b_mem_req, b_mem_we, b_run, b_fault;
    logic [31:0] b_retired;
    logic [5:0]  b_state;

    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int           n_tests = 0;
    int           n_fail = 0;
    logic [31:0]  exp_ret = '0;

    always #5 clk = ~clk;

    ctrl_seq_hs u_dut (
        .clk(clk), .reset_n(reset_n), .ir_data(ir_data), .con_out(con_out),
        .mem_ack(mem_ack), .alu_done(alu_done), .stop(stop), .resume(resume),
        .ctl(ctl), .alu_op(alu_op), .alu_start(alu_start), .mem_req(mem_req),
        .mem_we(mem_we), .run(run), .fault(fault), .retired(retired),
        .state_dbg(state_dbg)
    );

    ctrl_seq_hs #(.WAIT_TIMEOUT(4)) u_dut_tmo (
        .clk(clk), .reset_n(reset_n_b), .ir_data(32'h0), .con_out(1'b0),
        .mem_ack(1'b0), .alu_done(1'b1), .stop(1'b0), .resume(1'b0),
        .ctl(b_ctl), .alu_op(b_alu_op), .alu_start(b_alu_start),
        .mem_req(b_mem_req), .mem_we(b_mem_we), .run(b_run), .fault(b_fault),
        .retired(b_retired), .state_dbg(b_state)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [25:0] bt(input int i);
        logic [25:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Scoreboard: pop one expected word per cycle and compare at negedge.
    always @(negedge clk) begin
        if (exp_q.size() != 0)
            check(tag_q.pop_front(), exp_q.pop_front(),
                  {state_dbg, ctl, alu_op, mem_req, mem_we, alu_start, run, fault, retired})
                  ;
    end

    // Advance one cycle, apply handshake inputs, queue the expected outputs.
    task automatic exp_cycle(input string tag, input state_t st, input logic [25:0] c,
                             input logic [3:0] aop, input logic req, input logic we,
                             input logic start, input logic ack, input logic done,
                             input logic bnd);
        logic rn, flt;
        @(posedge clk);
        #1;
        resume   = 1'b0;
        mem_ack  = ack;
        alu_done = done;
        rn  = !(st == S_RST || st == S_HALT || st == S_FAULT);
        flt = (st == S_FAULT);
        exp_q.push_back({6'(st), c, aop, req, we, start, rn, flt, exp_ret});
        tag_q.push_back(tag);
        if (bnd) exp_ret = exp_ret + 32'd1;
    endtask

    task automatic fetch(input logic [31:0] ir, input int fm_wait, input logic dec_bnd);
        exp_cycle("F0", S_F0, bt(CTL_PC_OUT) | bt(CTL_MAR_IN) | bt(CTL_INC_PC) | bt(CTL_Z_IN),
                  4'd2, 0, 0, 0, 1, 1, 0);
        ir_data = ir;
        stop    = 1'b0;
        exp_cycle("F1", S_F1, bt(CTL_Z_LOW_OUT) | bt(CTL_PC_IN), 4'd0, 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < fm_wait; i++)
            exp_cycle("FM_wait", S_FM, bt(CTL_MDR_IN), 4'd0, 1, 0, 0, 0, 1, 0);
        exp_cycle("FM", S_FM, bt(CTL_MDR_IN), 4'd0, 1, 0, 0, 1, 1, 0);
        exp_cycle("F2", S_F2, bt(CTL_MDR_OUT) | bt(CTL_IR_IN), 4'd0, 0, 0, 0, 1, 1, 0);
        exp_cycle("DEC", S_DEC, '0, 4'd0, 0, 0, 0, 1, 1, dec_bnd);
    endtask

    task automatic add_body(input logic stop_mid);
        exp_cycle("add_E1", S_E1, bt(CTL_GRB) | bt(CTL_R_OUT) | bt(CTL_Y_IN), 4'd0, 0, 0, 0, 1, 1, 0);
        exp_cycle("add_EA", S_EA, bt(CTL_GRC) | bt(CTL_R_OUT) | bt(CTL_Z_IN), 4'd2, 0, 0, 1, 1, 1, 0);
        if (stop_mid) stop = 1'b1;
        exp_cycle("add_E3", S_E3, bt(CTL_Z_LOW_OUT) | bt(CTL_GRA) | bt(CTL_R_IN), 4'd0, 0, 0, 0, 1, 1, 1);
    endtask

    task automatic ld_front;
        exp_cycle("ld_E1", S_E1, bt(CTL_GRB) | bt(CTL_BA_OUT) | bt(CTL_Y_IN), 4'd0, 0, 0, 0, 1, 1, 0);
        exp_cycle("ld_EA", S_EA, bt(CTL_C_OUT) | bt(CTL_Z_IN), 4'd2, 0, 0, 1, 1, 1, 0);
        exp_cycle("ld_EM", S_EM, bt(CTL_Z_LOW_OUT) | bt(CTL_MAR_IN), 4'd0, 0, 0, 0, 1, 1, 0);
    endtask

    task automatic br_body(input logic cond);
        con_out = cond;
        exp_cycle("br_B1", S_B1, bt(CTL_GRA) | bt(CTL_R_OUT) | bt(CTL_CON_IN), 4'd0, 0, 0, 0, 1, 1, 0);
        exp_cycle("br_B2", S_B2, bt(CTL_PC_OUT) | bt(CTL_Y_IN), 4'd0, 0, 0, 0, 1, 1, 0);
        exp_cycle("br_B3", S_B3, bt(CTL_C_OUT) | bt(CTL_Z_IN), 4'd2, 0, 0, 0, 1, 1, 0);
        exp_cycle("br_B4", S_B4, bt(CTL_Z_LOW_OUT) | (cond ? bt(CTL_PC_IN) : 26'd0),
                  4'd0, 0, 0, 0, 1, 1, 1);
    endtask

    initial begin
        int fm_cycles;
        // Reset state
        exp_cycle("rst", S_RST, '0, 4'd0, 0, 0, 0, 1, 1, 0);
        exp_cycle("rst", S_RST, '0, 4'd0, 0, 0, 0, 1, 1, 0);
        reset_n = 1'b1;

        // add with zero-wait handshakes: 8 cycles, retired 0 -> 1
        fetch(32'h1800_0000, 0, 0);
        add_body(1'b0);

        // ld with mem_ack delayed 3 cycles in MR
        fetch(32'h0000_0000, 0, 0);
        ld_front();
        for (int i = 0; i < 3; i++)
            exp_cycle("ld_MR_wait", S_MR, bt(CTL_MDR_IN), 4'd0, 1, 0, 0, 0, 1, 0);
        exp_cycle("ld_MR_ack", S_MR, bt(CTL_MDR_IN), 4'd0, 1, 0, 0, 1, 1, 0);
        exp_cycle("ld_WB", S_WB, bt(CTL_MDR_OUT) | bt(CTL_GRA) | bt(CTL_R_IN), 4'd0, 0, 0, 0, 1, 1, 1);

        // mul with alu_done on the fifth EA cycle
        fetch(32'h7000_0000, 0, 0);
        exp_cycle("mul_E1", S_E1, bt(CTL_GRA) | bt(CTL_R_OUT) | bt(CTL_Y_IN), 4'd0, 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 5; i++)
            exp_cycle("mul_EA", S_EA, bt(CTL_GRB) | bt(CTL_R_OUT) | bt(CTL_Z_IN), 4'd4,
                      0, 0, (i == 0), 1, (i == 4), 0);
        exp_cycle("mul_LO", S_LO, bt(CTL_Z_LOW_OUT) | bt(CTL_LO_IN), 4'd0, 0, 0, 0, 1, 1, 0);
        exp_cycle("mul_HI", S_HI, bt(CTL_Z_HIGH_OUT) | bt(CTL_HI_IN), 4'd0, 0, 0, 0, 1, 1, 1);

        // br not taken, then taken; FM waits 2 cycles on the second
        fetch(32'h9000_0000, 0, 0);
        br_body(1'b0);
        fetch(32'h9000_0000, 2, 0);
        br_body(1'b1);

        // stop mid-add -> HALT after E3; resume (with stop still high) -> F0
        fetch(32'h1800_0000, 0, 0);
        add_body(1'b1);
        exp_cycle("halt", S_HALT, '0, 4'd0, 0, 0, 0, 1, 1, 0);
        exp_cycle("halt", S_HALT, '0, 4'd0, 0, 0, 0, 1, 1, 0);
        resume = 1'b1;

        // nop retires in DEC
        fetch(32'hC800_0000, 0, 1);

        // opcode 29 -> FAULT, sticky until reset
        fetch(32'hE800_0000, 0, 0);
        exp_cycle("fault", S_FAULT, '0, 4'd0, 0, 0, 0, 1, 1, 0);
        exp_cycle("fault", S_FAULT, '0, 4'd0, 0, 0, 0, 1, 1, 0);
        reset_n = 1'b0;
        exp_ret = '0;
        exp_cycle("rst_from_fault", S_RST, '0, 4'd0, 0, 0, 0, 1, 1, 0);
        reset_n = 1'b1;

        // reset while waiting in MR
        fetch(32'h0000_0000, 0, 0);
        ld_front();
        exp_cycle("ld_MR_wait", S_MR, bt(CTL_MDR_IN), 4'd0, 1, 0, 0, 0, 1, 0);
        reset_n = 1'b0;
        exp_ret = '0;
        exp_cycle("rst_in_MR", S_RST, '0, 4'd0, 0, 0, 0, 0, 1, 0);
        @(posedge clk);
        @(posedge clk);
        reset_n = 1'b1;

        // WAIT_TIMEOUT=4 instance, mem_ack stuck low in FM
        @(posedge clk);
        #1;
        reset_n_b = 1'b1;
        fm_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b_state == 6'(S_FM)) fm_cycles++;
            if (b_state == 6'(S_FAULT)) break;
        end
        check("tmo_fm_cycles", W'(fm_cycles), W'(4));
        check("tmo_state", W'(b_state), W'(S_FAULT));
        check("tmo_fault_run", W'({b_fault, b_run, b_mem_req}), W'(3'b100));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
